// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the store datapath and data memory, drained in order over req/ack.
// Optional store-to-load forwarding is built when STORE_FWD_EN is defined.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [AW-1:0]              st_addr,
  input  logic [31:0]                st_wdata,
  input  logic [3:0]                 st_wstrb,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [31:0]                ld_fwd_data,
  output logic [3:0]                 ld_fwd_strb,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH+1)-1:0] sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-3:0] r_ent_addr [DEPTH];
  logic [31:0]   r_ent_data [DEPTH];
  logic [3:0]    r_ent_strb [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;

  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic          w_req_nxt;
  logic [PW-1:0] w_ld_ptr;
  logic          w_unused;

  assign st_ready = (r_count != CW'(DEPTH));
  // Zero-strobe stores are handshaked but never occupy an entry.
  assign w_push   = st_valid && st_ready && (st_wstrb != 4'b0000);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_req_nxt   = r_mem_req;
    w_ld_ptr    = r_rd_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_pop = 1'b1;
          // Next head is already stored, so the following request issues without a bubble.
          if (r_count != CW'(1)) begin
            w_load   = 1'b1;
            w_ld_ptr = r_rd_ptr + PW'(1);
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_wr_ptr] <= st_addr[AW-1:2];
      r_ent_data[r_wr_ptr] <= st_wdata;
      r_ent_strb[r_wr_ptr] <= st_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_req <= w_req_nxt;
      if (w_load) begin
        r_mem_addr  <= {r_ent_addr[w_ld_ptr], 2'b00};
        r_mem_wdata <= r_ent_data[w_ld_ptr];
        r_mem_wstrb <= r_ent_strb[w_ld_ptr];
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign sb_count  = r_count;
  assign sb_empty  = (r_count == '0);

`ifdef STORE_FWD_EN
  logic [31:0]   w_fwd_data;
  logic [3:0]    w_fwd_strb;
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so a younger matching byte overwrites an older one.
  always_comb begin
    w_fwd_data = '0;
    w_fwd_strb = '0;
    w_idx      = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_ent_addr[w_idx] == ld_addr[AW-1:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (r_ent_strb[w_idx][b]) begin
            w_fwd_data[8*b +: 8] = r_ent_data[w_idx][8*b +: 8];
            w_fwd_strb[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign ld_fwd_data = w_fwd_data;
  assign ld_fwd_strb = w_fwd_strb;
  assign ld_hit      = |w_fwd_strb;
  assign w_unused    = ^{st_addr[1:0], ld_addr[1:0]};
`else
  assign ld_fwd_data = '0;
  assign ld_fwd_strb = '0;
  assign ld_hit      = 1'b0;
  assign w_unused    = ^{st_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_fwd_data;
  logic [3:0]    ld_fwd_strb;
  logic          sb_empty;
  logic [CW-1:0] sb_count;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_fwd_data(ld_fwd_data),
    .ld_fwd_strb(ld_fwd_strb),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } ent_t;

  ent_t          q[$];
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [3:0]    m_strb;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Youngest pending store supplying each byte lane of the load's word.
  task automatic model_fwd(output logic [31:0] d, output logic [3:0] s);
    d = '0;
    s = '0;
`ifdef STORE_FWD_EN
    for (int b = 0; b < 4; b++) begin
      for (int i = int'(q.size()) - 1; i >= 0; i--) begin
        if ((q[i].addr[AW-1:2] == ld_addr[AW-1:2]) && q[i].strb[b]) begin
          d[8*b +: 8] = q[i].data[8*b +: 8];
          s[b]        = 1'b1;
          break;
        end
      end
    end
`endif
  endtask

  task automatic step();
    logic [31:0] fd;
    logic [3:0]  fs;
    bit          ready;
    bit          acked;
    ent_t        e;
    #1;
    if (rst_n) begin
      model_fwd(fd, fs);
      chk("st_ready", 64'(st_ready), 64'(q.size() != DEPTH));
      chk("ld_fwd_strb", 64'(ld_fwd_strb), 64'(fs));
      chk("ld_fwd_data", 64'(ld_fwd_data), 64'(fd));
      chk("ld_hit", 64'(ld_hit), 64'(|fs));
    end
    ready = (q.size() != DEPTH);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_req  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_strb = '0;
    end else begin
      acked = m_req && mem_ack;
      if (acked) void'(q.pop_front());
      if (acked && q.size() == 0) begin
        m_req = 1'b0;
      end else if ((acked || !m_req) && q.size() != 0) begin
        m_req  = 1'b1;
        m_addr = q[0].addr;
        m_data = q[0].data;
        m_strb = q[0].strb;
      end
      if (st_valid && ready && st_wstrb != 4'b0000) begin
        e.addr = {st_addr[AW-1:2], 2'b00};
        e.data = st_wdata;
        e.strb = st_wstrb;
        q.push_back(e);
      end
    end
    #1;
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_data));
    chk("mem_wstrb", 64'(mem_wstrb), 64'(m_strb));
    chk("sb_count", 64'(sb_count), 64'(q.size()));
    chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic ack);
    st_valid = v;
    st_addr  = a;
    st_wdata = d;
    st_wstrb = s;
    mem_ack  = ack;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] fa [4];
    int unsigned   guard;

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_wdata = '0;
    st_wstrb = '0;
    mem_ack  = 1'b0;
    ld_addr  = '0;
    m_req    = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_strb   = '0;

    // Reset held for two cycles
    drive(0, '0, '0, '0, 0);
    drive(0, '0, '0, '0, 0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_sb_empty", 64'(sb_empty), 64'd1);
    chk("rst_sb_count", 64'(sb_count), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;

    // Single store, delayed ack
    drive(1, 32'h1002, 32'h00AB_0000, 4'b0100, 0);
    chk("single_req_not_yet", 64'(mem_req), 64'd0);
    drive(0, '0, '0, '0, 0);
    chk("single_req", 64'(mem_req), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h1000);
    chk("single_wstrb", 64'(mem_wstrb), 64'b0100);
    chk("single_wdata", 64'(mem_wdata), 64'h00AB_0000);
    repeat (3) drive(0, '0, '0, '0, 0);
    chk("single_hold_addr", 64'(mem_addr), 64'h1000);
    drive(0, '0, '0, '0, 1);
    chk("single_ack_req", 64'(mem_req), 64'd0);
    chk("single_ack_empty", 64'(sb_empty), 64'd1);

    // Fill to DEPTH, refused fifth store, then back-to-back drain
    for (int i = 0; i < 4; i++) begin
      fa[i] = 32'h200 + 32'(i * 4);
      drive(1, fa[i], 32'hA000_0000 + 32'(i), 4'hF, 0);
    end
    chk("fill_count", 64'(sb_count), 64'd4);
    chk("fill_ready", 64'(st_ready), 64'd0);
    drive(1, 32'h300, 32'hDEAD_BEEF, 4'hF, 0);
    chk("fill_refused", 64'(sb_count), 64'd4);
    chk("fill_head", 64'(mem_addr), 64'(fa[0]));
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, '0, 1);
      if (i < 3) begin
        chk("b2b_req", 64'(mem_req), 64'd1);
        chk("b2b_addr", 64'(mem_addr), 64'(fa[i+1]));
      end else begin
        chk("b2b_done", 64'(mem_req), 64'd0);
      end
    end

    // Concurrent push and pop at count 2, wrapping the pointers
    drive(1, 32'h400, 32'h1111_1111, 4'hF, 0);
    drive(1, 32'h404, 32'h2222_2222, 4'hF, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h408 + 32'(i * 4), 32'h3000_0000 + 32'(i), 4'hF, 1);
      chk("pushpop_count", 64'(sb_count), 64'd2);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      drive(0, '0, '0, '0, 1);
      guard++;
    end
    chk("pushpop_drained", 64'(sb_count), 64'd0);

    // Zero-strobe store and reset with a pending request
    drive(1, 32'h500, 32'hFFFF_FFFF, 4'b0000, 0);
    chk("zstrb_count", 64'(sb_count), 64'd0);
    drive(0, '0, '0, '0, 0);
    chk("zstrb_noreq", 64'(mem_req), 64'd0);
    drive(1, 32'h600, 32'h0606_0606, 4'hF, 0);
    drive(0, '0, '0, '0, 0);
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    drive(0, '0, '0, '0, 0);
    chk("rst_drop_req", 64'(mem_req), 64'd0);
    chk("rst_drop_count", 64'(sb_count), 64'd0);
    rst_n = 1'b1;
    drive(0, '0, '0, '0, 0);
    chk("rst_no_reissue", 64'(mem_req), 64'd0);

    // Forwarding: word store then younger byte store to the same word
    drive(1, 32'h20, 32'h1122_3344, 4'b1111, 0);
    drive(1, 32'h20, 32'h0000_00AA, 4'b0001, 0);
    ld_addr = 32'h21;
    #1;
`ifdef STORE_FWD_EN
    chk("fwd_hit", 64'(ld_hit), 64'd1);
    chk("fwd_strb", 64'(ld_fwd_strb), 64'hF);
    chk("fwd_data", 64'(ld_fwd_data), 64'h1122_33AA);
`else
    chk("fwd_hit", 64'(ld_hit), 64'd0);
    chk("fwd_strb", 64'(ld_fwd_strb), 64'd0);
`endif
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      drive(0, '0, '0, '0, 1);
      guard++;
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      ld_addr = 32'h40 + 32'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 2) != 0),
            32'h40 + 32'($urandom_range(0, 15)),
            $urandom,
            ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
            1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      drive(0, '0, '0, '0, 1);
      guard++;
    end
    drive(0, '0, '0, '0, 0);
    chk("final_empty", 64'(sb_empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
